radix4_step_sequencer: RTL and testbench
========================================

// Module: radix4_step_sequencer
// PURPOSE
//  Consumes the divided clock from clock_divider, sampled as a level in the clk domain, and turns each
//  rising edge into a one-cycle step strobe. Sequences a DATA_W-bit radix-4 datapath through DATA_W/2
//  digit iterations, one per strobe, using a start/busy/done handshake. Sits between clock_divider and
//  the radix-4 digit datapath. No logic is clocked by div_clk; everything runs on clk.
// PARAMETERS
//  DATA_W      16   operand width in bits; must be even and >= 4; NUM_DIGITS = DATA_W/2
//  TIMEOUT     64   max clk cycles in RUN with no div_clk rising edge before the sequence aborts
//  IDX_W       $clog2(DATA_W/2)  derived localparam, not overridable
// PORTS
//  clk         in   1      system clock; sole clock
//  rst         in   1      synchronous reset, active-high
//  div_clk     in   1      clock_divider output, treated as a data level (period 32 clk, high for 16)
//  start       in   1      request a new sequence; honoured only in IDLE
//  abort       in   1      cancel the running sequence
//  busy        out  1      high in RUN and DONE
//  step_en     out  1      one-clk strobe: datapath performs iteration digit_idx
//  digit_idx   out  IDX_W  current digit index, 0..NUM_DIGITS-1
//  done        out  1      one-clk pulse after the final step completes
//  timeout     out  1      sticky; set when the watchdog expires; cleared by the next accepted start or by rst
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, step_en=0, digit_idx=0, done=0, timeout=0; edge-detect flops=0; watchdog=0.
//  Edge detect: div_q<=div_clk; div_q_d<=div_q; tick = div_q & ~div_q_d (combinational).
//  The first rising edge after reset is detected as a tick, because div_q_d resets to 0.
//  Latency: div_clk sampled high at edge k -> tick during cycle k+1 -> step_en registered high after edge k+1.
//  States: IDLE, RUN, DONE (2-bit encoding).
//   IDLE: start=1 -> RUN; digit_idx<=0; watchdog<=0; timeout<=0. Ticks in IDLE are ignored.
//   RUN:  tick=1 -> step_en<=1 for one cycle; digit_idx holds its value during the strobe.
//         In the cycle after the strobe: if digit_idx==NUM_DIGITS-1 -> DONE; else digit_idx<=digit_idx+1.
//         The watchdog counts clk cycles and clears on every tick.
//         When the watchdog reaches TIMEOUT-1 with no tick -> IDLE; timeout<=1; done stays 0.
//   DONE: done=1 for exactly one cycle -> IDLE; digit_idx<=0.
//  Handshake: start is ignored while busy=1 (no queuing); it may be held high continuously.
//   A start held high in IDLE restarts immediately after DONE, so busy drops for one cycle.
//  Simultaneous events:
//   start and tick in the same IDLE cycle: start is accepted; that tick is not used; the first step comes on the next tick.
//   abort in RUN: -> IDLE next cycle; step_en forced to 0 that cycle; no done; timeout unchanged.
//   abort together with tick in RUN: abort wins; no step_en.
//   abort in IDLE or DONE: no effect; the done pulse still occurs.
//   rst mid-sequence: immediate return to reset values; an in-flight step_en is dropped.
//  digit_idx never exceeds NUM_DIGITS-1. It does not wrap in RUN; it wraps to 0 only via DONE, abort, or timeout.
//  All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
//  Shared defs header radix4_defs.vh: state encodings (ST_IDLE=0, ST_RUN=1, ST_DONE=2), the
//   DIV_PERIOD=32 constant, and the NUM_DIGITS(DATA_W) macro, shared with the datapath and clock_divider.
//  Sub-module rise_detect: 2-flop level-to-pulse converter (clk, rst, lvl_in -> pulse); reused elsewhere.
//  Top level: FSM, digit counter, watchdog counter, sticky timeout flag.
// TESTING
//  Run all scenarios with DATA_W=8 (NUM_DIGITS=4), TIMEOUT=64, and div_clk driven by a real clock_divider.
//  1 Nominal: start pulse in IDLE -> exactly 4 step_en pulses, 32 clk apart, with digit_idx 0,1,2,3;
//    done pulses once, 1 cycle after the last step; busy deasserts 2 cycles after the last step_en.
//  2 Latency: div_clk forced 0->1 at cycle 100 while in RUN -> step_en high at cycle 102 only, width 1 clk.
//  3 Abort: abort asserted after the 2nd step_en, coincident with the 3rd tick -> no 3rd step_en;
//    busy=0 next cycle; done never pulses; a new start then runs all 4 digits from digit_idx=0.
//  4 Timeout: div_clk held low after start -> IDLE after 64 clk; timeout=1, done=0;
//    the next start clears timeout in its acceptance cycle.
//  5 Start while busy and start+tick together: extra start pulses in RUN change nothing (still 4 steps);
//    start coincident with a tick in IDLE -> first step_en on the following tick (32 clk later).
//  6 Reset: rst asserted for 1 cycle between the 2nd and 3rd steps -> all outputs 0 next cycle;
//    no further step_en without a new start.

Source files
------------

// File: rtl/radix4_step_sequencer_pkg.sv
// Shared definitions for the radix-4 step sequencer: FSM encoding, divider period
// and the digit-count helper used to size the digit counter.
package radix4_step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int DIV_PERIOD = 32;

    function automatic int num_digits(input int data_w);
        return data_w / 2;
    endfunction

endpackage

// File: rtl/radix4_step_sequencer_rise_detect.sv
// Two-flop level-to-pulse converter: pulse is high for the one clk cycle after
// lvl_in is first sampled high.
module radix4_step_sequencer_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl_in,
    output logic pulse
);

    logic lvl_q;
    logic lvl_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            lvl_q     <= lvl_in;
            lvl_dly_q <= lvl_q;
        end
    end

    // Delayed copy resets low, so a level already high after reset reads as an edge.
    assign pulse = lvl_q & ~lvl_dly_q;

endmodule

// File: rtl/radix4_step_sequencer.sv
// Turns rising edges of the divided clock into step strobes and walks a radix-4
// datapath through DATA_W/2 digit iterations, with abort and a no-edge watchdog.
module radix4_step_sequencer
    import radix4_step_sequencer_pkg::*;
#(
    parameter int  DATA_W  = 16,
    parameter int  TIMEOUT = 64,
    localparam int IDX_W   = $clog2(DATA_W / 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_clk,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             step_en,
    output logic [IDX_W-1:0] digit_idx,
    output logic             done,
    output logic             timeout
);

    localparam int NUM_DIGITS = num_digits(DATA_W);
    localparam int WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    seq_state_t       state_q;
    logic             busy_q;
    logic             step_en_q;
    logic [IDX_W-1:0] idx_q;
    logic             done_q;
    logic             timeout_q;
    logic [WD_W-1:0]  wd_q;
    logic             tick;
    logic             idx_last;

    radix4_step_sequencer_rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .lvl_in (div_clk),
        .pulse  (tick)
    );

    assign idx_last = (idx_q == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            step_en_q <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            step_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A tick landing with the accepted start is deliberately not consumed.
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        idx_q     <= '0;
                        wd_q      <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        wd_q    <= '0;
                    end else if (step_en_q && idx_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        if (step_en_q) begin
                            idx_q <= idx_q + 1'b1;
                        end
                        if (tick) begin
                            step_en_q <= 1'b1;
                            wd_q      <= '0;
                        end else if (wd_q == WD_LAST) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            idx_q     <= '0;
                            wd_q      <= '0;
                            timeout_q <= 1'b1;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign step_en   = step_en_q;
    assign digit_idx = idx_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_radix4_step_sequencer.sv
// Directed bench for radix4_step_sequencer at DATA_W=8, TIMEOUT=64, fed by a
// behavioural divide-by-32 counter or a forced level.
module tb_radix4_step_sequencer;

    logic       clk;
    logic       rst;
    logic       div_clk;
    logic       start;
    logic       abort;
    logic       busy;
    logic       step_en;
    logic [1:0] digit_idx;
    logic       done;
    logic       timeout;

    logic [4:0] div_cnt = '0;
    logic       div_force_en;
    logic       div_force;

    int n_chk;
    int n_fail;
    int cyc;
    int step_cyc[$];
    int step_idx[$];
    int done_cyc[$];

    radix4_step_sequencer #(
        .DATA_W  (8),
        .TIMEOUT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_clk   (div_clk),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .step_en   (step_en),
        .digit_idx (digit_idx),
        .done      (done),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock divider: period 32 clk, high for 16, output registered on clk.
    always @(posedge clk) div_cnt <= div_cnt + 1'b1;
    assign div_clk = div_force_en ? div_force : div_cnt[4];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (step_en === 1'b1) begin
            step_cyc.push_back(cyc);
            step_idx.push_back(int'(digit_idx));
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        step_cyc.delete();
        step_idx.delete();
        done_cyc.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
    endtask

    task automatic run_to_idle(input int max, input bit poke_start, output int fall);
        fall = -1;
        for (int i = 0; i < max; i++) begin
            start = poke_start && (busy === 1'b1) && (i % 10 == 5);
            cycle();
            if (busy === 1'b0) begin
                fall = cyc;
                break;
            end
        end
        start = 1'b0;
        check_eq("run_bound", (fall >= 0) ? 1 : 0, 1);
    endtask

    task automatic check_nominal(input string tag, input int fall);
        check_eq($sformatf("%s_steps", tag), step_cyc.size(), 4);
        check_eq($sformatf("%s_dones", tag), done_cyc.size(), 1);
        if (step_cyc.size() == 4 && done_cyc.size() == 1) begin
            for (int i = 0; i < 4; i++)
                check_eq($sformatf("%s_idx%0d", tag, i), step_idx[i], i);
            for (int i = 1; i < 4; i++)
                check_eq($sformatf("%s_gap%0d", tag, i), step_cyc[i] - step_cyc[i-1], 32);
            check_eq($sformatf("%s_done_lat", tag), done_cyc[0] - step_cyc[3], 1);
            check_eq($sformatf("%s_busy_lat", tag), fall - step_cyc[3], 2);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int fall;
        int c2;
        int c0;
        int got_done;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        div_force_en = 1'b1; div_force = 1'b0;
        n_chk = 0; n_fail = 0; cyc = 0;

        // Reset values
        cycles(3);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_step_en", int'(step_en), 0);
        check_eq("rst_idx", int'(digit_idx), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        div_force_en = 1'b0;
        cycles(5);

        // Nominal sequence from the divider
        clear_log();
        pulse_start();
        check_eq("nom_busy_on", int'(busy), 1);
        run_to_idle(300, 1'b0, fall);
        check_nominal("nom", fall);
        check_eq("nom_timeout", int'(timeout), 0);

        // Extra start pulses while busy change nothing
        clear_log();
        pulse_start();
        run_to_idle(300, 1'b1, fall);
        check_nominal("sbusy", fall);

        // Abort coincident with the 3rd tick
        clear_log();
        pulse_start();
        for (int i = 0; i < 200 && step_cyc.size() < 2; i++) cycle();
        check_eq("ab_two_steps", step_cyc.size(), 2);
        cycles(31);
        do_abort();
        check_eq("ab_step_en", int'(step_en), 0);
        check_eq("ab_busy", int'(busy), 0);
        check_eq("ab_idx", int'(digit_idx), 0);
        cycles(100);
        check_eq("ab_no_more_steps", step_cyc.size(), 2);
        check_eq("ab_no_done", done_cyc.size(), 0);
        check_eq("ab_timeout", int'(timeout), 0);
        clear_log();
        pulse_start();
        run_to_idle(300, 1'b0, fall);
        check_nominal("ab_rerun", fall);

        // Start held high restarts right after DONE with a one-cycle busy gap
        clear_log();
        start = 1'b1;
        got_done = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
        end
        check_eq("hold_done_seen", got_done, 1);
        cycle();
        check_eq("hold_busy_gap", int'(busy), 0);
        cycle();
        check_eq("hold_busy_again", int'(busy), 1);
        check_eq("hold_idx", int'(digit_idx), 0);
        start = 1'b0;
        do_abort();
        check_eq("hold_abort_busy", int'(busy), 0);

        // Reset between the 2nd and 3rd steps
        clear_log();
        pulse_start();
        for (int i = 0; i < 200 && step_cyc.size() < 2; i++) cycle();
        check_eq("rs_two_steps", step_cyc.size(), 2);
        cycles(9);
        check_eq("rs_pre_idx", int'(digit_idx), 2);
        check_eq("rs_pre_busy", int'(busy), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("rs_busy", int'(busy), 0);
        check_eq("rs_step_en", int'(step_en), 0);
        check_eq("rs_idx", int'(digit_idx), 0);
        check_eq("rs_done", int'(done), 0);
        check_eq("rs_timeout", int'(timeout), 0);
        cycles(100);
        check_eq("rs_no_more_steps", step_cyc.size(), 2);
        check_eq("rs_idle_busy", int'(busy), 0);

        // Forced div_clk: edge-to-strobe latency
        div_force_en = 1'b1; div_force = 1'b0;
        cycles(4);
        clear_log();
        pulse_start();
        cycles(10);
        div_force = 1'b1;
        cycle();
        check_eq("lat_r1", int'(step_en), 0);
        cycle();
        check_eq("lat_r2", int'(step_en), 1);
        check_eq("lat_idx", int'(digit_idx), 0);
        cycle();
        check_eq("lat_r3", int'(step_en), 0);
        check_eq("lat_steps", step_cyc.size(), 1);
        do_abort();
        check_eq("lat_abort_busy", int'(busy), 0);

        // Watchdog expiry with div_clk held low
        div_force = 1'b0;
        cycles(4);
        clear_log();
        pulse_start();
        check_eq("to_busy_start", int'(busy), 1);
        cycles(63);
        check_eq("to_busy_64", int'(busy), 1);
        check_eq("to_flag_early", int'(timeout), 0);
        cycle();
        check_eq("to_busy_65", int'(busy), 0);
        check_eq("to_flag", int'(timeout), 1);
        check_eq("to_no_done", done_cyc.size(), 0);
        cycles(5);
        check_eq("to_sticky", int'(timeout), 1);
        pulse_start();
        check_eq("to_cleared", int'(timeout), 0);
        check_eq("to_restart_busy", int'(busy), 1);
        do_abort();

        // Start coincident with a tick in IDLE
        cycles(4);
        clear_log();
        div_force = 1'b1;
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        c0 = cyc;
        check_eq("st_busy", int'(busy), 1);
        check_eq("st_no_step", int'(step_en), 0);
        cycles(14);
        div_force = 1'b0;
        cycles(16);
        div_force = 1'b1;
        cycles(2);
        check_eq("st_steps", step_cyc.size(), 1);
        if (step_cyc.size() == 1) check_eq("st_step_delay", step_cyc[0] - c0, 32);
        check_eq("st_step_idx", (step_idx.size() == 1) ? step_idx[0] : -1, 0);
        do_abort();
        check_eq("st_abort_busy", int'(busy), 0);
        c2 = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
